md_sequencer: RTL
=================

MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL expose parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 SHALL expose parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 SHALL have port `clk`, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port `reset`, input, 1 bit: asynchronous, active-high.
REQ-005 SHALL have port `start`, input, 1 bit: E-stage MULT/MULTU/DIV/DIVU issue strobe.
REQ-006 SHALL have port `md_op`, input, 4 bits: operation code from md_pkg (MULT, MULTU, DIV, DIVU, MTHI, MTLO, NONE).
REQ-007 SHALL have port `rs_data`, input, 32 bits: forwarded operand A.
REQ-008 SHALL have port `rt_data`, input, 32 bits: forwarded operand B.
REQ-009 SHALL have port `rd_hi`, input, 1 bit: 1 selects HI on `rdata`, 0 selects LO.
REQ-010 SHALL have port `d_is_md`, input, 1 bit: D-stage instruction uses the MD unit.
REQ-011 SHALL have port `busy`, output, 1 bit: operation in progress.
REQ-012 SHALL have port `md_stall`, output, 1 bit: stall request to the pipeline stall logic.
REQ-013 SHALL have port `rdata`, output, 32 bits: HI or LO, per `rd_hi`.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, with a down-counter `cnt` sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 SHALL, in IDLE on `start`=1 with a MUL/DIV `md_op` at edge t, latch operands and op, load `cnt`=N-1 (N per op), and enter RUN.
REQ-016 SHALL assert `busy` for exactly N cycles, from edge t through edge t+N.
REQ-017 SHALL write HI/LO at edge t+N, decrement `cnt` each RUN cycle, and return to IDLE when `cnt`=0.
REQ-018 SHALL compute MULT as a signed 32x32->64 multiply and MULTU as unsigned, with HI=[63:32] and LO=[31:0].
REQ-019 SHALL compute DIV/DIVU with LO=quotient truncated toward zero and HI=remainder carrying the dividend's sign (DIV).
REQ-020 SHALL leave HI/LO unchanged on divide by zero.
REQ-021 SHALL write HI or LO with `rs_data` at the next edge on MTHI/MTLO in IDLE with `busy`=0, with zero latency and no busy cycle.
REQ-022 SHALL ignore, with no state change, `start` or MTHI/MTLO arriving while in RUN.
REQ-023 SHALL drive `rdata` combinationally from the committed HI/LO; no in-flight value is visible.
REQ-024 SHALL drive `md_stall` = `d_is_md` & (`start` | `busy`).
REQ-025 SHALL deassert `md_stall` in the cycle after the final busy cycle, so a following MFHI proceeds and reads the new value.

Reset
REQ-026 SHALL, on `reset`=1 at any time including mid-RUN, force state=IDLE, `cnt`=0, HI=0, LO=0, and latched operands=0, abandoning any operation.
REQ-027 SHALL hold `busy`=0, `md_stall`=0, and `rdata`=0 while reset is asserted.

Configuration
REQ-028 SHALL provide macro MD_DIVZERO_FAST_EN.
REQ-029 SHALL, when MD_DIVZERO_FAST_EN is defined, complete DIV/DIVU with `rt_data`=0 with no RUN entry and `busy` never asserted.
REQ-030 SHALL, when MD_DIVZERO_FAST_EN is undefined, occupy the full DIV_CYCLES for a zero divisor, with HI/LO unchanged.

Structure
REQ-031 SHALL place `md_op` encodings, the FSM state enum, and default latency constants in shared package md_pkg.
REQ-032 SHALL instantiate one combinational sub-module, md_arith, that computes the {HI, LO} result from the latched op and operands; md_sequencer owns sequencing and the HI/LO registers.

Verification
REQ-033 SHALL verify MULT with 0xFFFFFFFF, 0x00000002 -> busy 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFE; MULTU with the same operands -> HI=0x00000001 and LO=0xFFFFFFFE.
REQ-034 SHALL verify DIV with -7 (0xFFFFFFF9) and 2 -> busy 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-035 SHALL verify MTHI 0x1234 during RUN -> HI unchanged; MTHI 0x1234 in IDLE -> HI=0x00001234 at the next edge.
REQ-036 SHALL verify DIVU by 0 with HI=LO=0xA5A5A5A5 -> HI/LO unchanged, busy 0 cycles with the macro defined and 10 cycles without it.
REQ-037 SHALL verify reset asserted in cycle 3 of a MULT -> busy=0 immediately and HI=LO=0; a subsequent MULT 3x4 -> LO=12.
REQ-038 SHALL verify `d_is_md`=1 held during a MULT -> md_stall high for the start cycle plus 5 busy cycles, then low with `rdata` equal to the new LO.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared op encodings, FSM states and default latencies
// for the HI/LO multiply/divide sequencer (md_sequencer, md_arith).
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_muldiv(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || is_div(op);
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational {HI, LO} result for the latched op/operands.
// Ports: op, a, b in; hi, lo, we out (we=0 on divide by zero or non-arith op).
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        we
);

  logic [63:0] xa;
  logic [63:0] xb;
  logic [63:0] prod;
  md_op_t      opc;

  always_comb begin
    opc  = md_op_t'(op);
    xa   = '0;
    xb   = '0;
    prod = '0;
    hi   = '0;
    lo   = '0;
    we   = 1'b0;
    unique case (opc)
      MD_MULT: begin
        // sign-extend so the low 64 bits of an unsigned
        // 64x64 product equal the signed 32x32 result
        xa   = {{32{a[31]}}, a};
        xb   = {{32{b[31]}}, b};
        prod = xa * xb;
        hi   = prod[63:32];
        lo   = prod[31:0];
        we   = 1'b1;
      end
      MD_MULTU: begin
        xa   = {32'd0, a};
        xb   = {32'd0, b};
        prod = xa * xb;
        hi   = prod[63:32];
        lo   = prod[31:0];
        we   = 1'b1;
      end
      MD_DIV: begin
        if (b != 32'd0) begin
          lo = $signed(a) / $signed(b);
          hi = $signed(a) % $signed(b);
          we = 1'b1;
        end
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          lo = a / b;
          hi = a % b;
          we = 1'b1;
        end
      end
      default: begin
        we = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle MULT/DIV sequencer owning HI/LO, with MTHI/MTLO,
// stall generation and HI/LO read mux.
// Ports: clk, reset (async high), start, md_op, rs_data, rt_data, rd_hi,
// d_is_md in; busy, md_stall, rdata out.
// Macro MD_DIVZERO_FAST_EN: DIV/DIVU by zero finish at issue, no RUN.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        rd_hi,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] rdata
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  md_state_t      state;
  logic [CW-1:0]  cnt;
  logic [31:0]    hi;
  logic [31:0]    lo;
  logic [3:0]     op_q;
  logic [31:0]    a_q;
  logic [31:0]    b_q;

  logic [31:0]    res_hi;
  logic [31:0]    res_lo;
  logic           res_we;
  md_op_t         op_i;
  logic           skip;
  logic           launch;

  assign op_i = md_op_t'(md_op);

`ifdef MD_DIVZERO_FAST_EN
  // zero divisor: result is "unchanged", so no need to spend cycles
  assign skip = is_div(op_i) && (rt_data == 32'd0);
`else
  assign skip = 1'b0;
`endif

  assign launch = start && is_muldiv(op_i) && !skip;

  md_arith u_arith (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .hi (res_hi),
    .lo (res_lo),
    .we (res_we)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= MD_NONE;
      a_q   <= '0;
      b_q   <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (launch) begin
            op_q  <= md_op;
            a_q   <= rs_data;
            b_q   <= rt_data;
            cnt   <= is_div(op_i) ? CW'(DIV_CYCLES - 1)
                                  : CW'(MULT_CYCLES - 1);
            state <= S_RUN;
            busy  <= 1'b1;
          end else if (op_i == MD_MTHI) begin
            hi <= rs_data;
          end else if (op_i == MD_MTLO) begin
            lo <= rs_data;
          end
        end
        S_RUN: begin
          // new issues and MTHI/MTLO are dropped while running
          if (cnt == '0) begin
            if (res_we) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign md_stall = !reset && d_is_md && (start || busy);
  assign rdata    = rd_hi ? hi : lo;

endmodule
